sram_port_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer in front of sram_core. It accepts independent read/write requests from ports A and B, latches the winner's command, and drives the core's enable/read_not_write/addr/data_in until the core's ready. It then returns read data with a one-cycle ack to the winner. A watchdog terminates any access whose ready never arrives and flags an error.

---
 rtl/sram_port_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Round-robin arbiter and access sequencer that sits between two requester
// ports (A and B) and a single sram_core. The winner's command is latched so
// the core sees stable enable/rnw/addr/data for the whole access. A watchdog
// aborts an access whose ready never arrives and reports it as an error.
module sram_port_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // port A
  input  logic              a_req,
  input  logic              a_rnw,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  // port B
  input  logic              b_req,
  input  logic              b_rnw,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  // sram_core side
  output logic              mem_enable,
  output logic              mem_read_not_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_ready,
  // status
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Port identifiers used for the grant history and the latched winner.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // Last watchdog count before the access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              state;
  state_t              state_nx;

  logic                last_grant;
  logic                cmd_id;
  logic                cmd_rnw;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [7:0]          cnt;
  logic                err_flag;

  // Decoded arbitration/sequencing decisions for the current cycle.
  logic                grant;
  logic                grant_id;
  logic                done_ok;
  logic                done_timeout;

  // Next-state and arbitration decode; requests only matter in IDLE and
  // ready only matters in ACCESS.
  always_comb begin
    state_nx     = state;
    grant        = 1'b0;
    grant_id     = PORT_A;
    done_ok      = 1'b0;
    done_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (a_req && b_req) begin
          grant    = 1'b1;
          grant_id = (last_grant == PORT_A) ? PORT_B : PORT_A;
          state_nx = ACCESS;
        end else if (a_req) begin
          grant    = 1'b1;
          grant_id = PORT_A;
          state_nx = ACCESS;
        end else if (b_req) begin
          grant    = 1'b1;
          grant_id = PORT_B;
          state_nx = ACCESS;
        end else begin
          state_nx = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          done_ok  = 1'b1;
          state_nx = RESP;
        end else if (cnt == CNT_LAST) begin
          done_timeout = 1'b1;
          state_nx     = RESP;
        end else begin
          state_nx = ACCESS;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Command latch: winner's fields are captured once at grant and held
  // for the whole access regardless of what the requester does afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_id    <= PORT_A;
      cmd_rnw   <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (grant) begin
      cmd_id <= grant_id;
      if (grant_id == PORT_B) begin
        cmd_rnw   <= b_rnw;
        cmd_addr  <= b_addr;
        cmd_wdata <= b_wdata;
      end else begin
        cmd_rnw   <= a_rnw;
        cmd_addr  <= a_addr;
        cmd_wdata <= a_wdata;
      end
    end
  end

  // Watchdog counter: cleared on grant, advanced while waiting for ready.
  // It stops at CNT_LAST because reaching it leaves ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (grant) begin
      cnt <= 8'd0;
    end else if (state == ACCESS && !done_ok && !done_timeout) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Error flag for the response: set on watchdog expiry, cleared on a
  // normal completion. Only visible through the winner's err during RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag <= 1'b0;
    end else if (done_ok) begin
      err_flag <= 1'b0;
    end else if (done_timeout) begin
      err_flag <= 1'b1;
    end
  end

  // Round-robin history: updated when the winner is acknowledged, so an
  // aborted (reset) access never counts as a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_B;
    end else if (state == RESP) begin
      last_grant <= cmd_id;
    end
  end

  // Read-data holding registers: only a successful read updates the
  // winner's copy; writes and timeouts leave both untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else if (done_ok && cmd_rnw) begin
      if (cmd_id == PORT_B) begin
        b_rdata <= mem_data_out;
      end else begin
        a_rdata <= mem_data_out;
      end
    end
  end

  // Output decode from registered state and flags only; core-side fields
  // are forced to zero outside ACCESS.
  always_comb begin
    mem_enable         = 1'b0;
    mem_read_not_write = 1'b0;
    mem_addr           = '0;
    mem_data_in        = '0;
    a_ack              = 1'b0;
    a_err              = 1'b0;
    b_ack              = 1'b0;
    b_err              = 1'b0;
    busy               = (state != IDLE);
    if (state == ACCESS) begin
      mem_enable         = 1'b1;
      mem_read_not_write = cmd_rnw;
      mem_addr           = cmd_addr;
      mem_data_in        = cmd_wdata;
    end else if (state == RESP) begin
      if (cmd_id == PORT_B) begin
        b_ack = 1'b1;
        b_err = err_flag;
      end else begin
        a_ack = 1'b1;
        a_err = err_flag;
      end
    end else begin
      mem_enable = 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a small behavioural sram_core
// model whose ready latency can be set per access or suppressed entirely.
module tb_sram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_rnw, b_req, b_rnw;
  logic [9:0] a_addr, b_addr;
  logic [3:0] a_wdata, b_wdata;
  logic       a_ack, a_err, b_ack, b_err;
  logic [3:0] a_rdata, b_rdata;
  logic       mem_enable, mem_read_not_write, mem_ready;
  logic [9:0] mem_addr;
  logic [3:0] mem_data_in, mem_data_out;
  logic       busy;

  sram_port_arbiter #(.ADDR_W(10), .DATA_W(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_rnw(a_rnw), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_rnw(b_rnw), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .mem_enable(mem_enable), .mem_read_not_write(mem_read_not_write),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- core model ----------------
  logic [3:0] mem [0:1023];
  logic [7:0] en_cnt;
  logic [7:0] lat = 8'd0;
  logic       no_ready = 1'b0;
  logic       preload = 1'b1;

  assign mem_ready    = mem_enable && !no_ready && (en_cnt == lat);
  assign mem_data_out = mem[mem_addr];

  always @(posedge clk) begin
    en_cnt <= mem_enable ? en_cnt + 8'd1 : 8'd0;
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 4'h0;
      mem[10'h3A5] <= 4'hC;
      mem[10'h010] <= 4'h7;
      mem[10'h200] <= 4'h2;
    end else if (mem_enable && mem_ready && !mem_read_not_write) begin
      mem[mem_addr] <= mem_data_in;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic       port;
    logic       err;
    logic [3:0] rdata;
    int         en_len;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic       addr_chk = 1'b0;
  logic [9:0] exp_mem_addr = 10'h000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ack(input logic port, input logic err, input logic [3:0] rd, input int len);
    exp_t e;
    e.port = port; e.err = err; e.rdata = rd; e.en_len = len;
    sb.push_back(e);
  endtask

  // Monitor: tracks mem_enable runs/gaps and pops the scoreboard on every ack.
  initial begin
    int   en_run = 0;
    int   low_run = 100;
    int   last_len = 0;
    bit   seen_en = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_enable) begin
        if (en_run == 0) begin
          if (seen_en) check("enable_gap_ge2", {31'd0, low_run >= 2}, 32'd1);
          seen_en = 1'b1;
        end
        en_run++;
        low_run = 0;
        if (addr_chk) check("mem_addr_stable", {22'd0, mem_addr}, {22'd0, exp_mem_addr});
      end else begin
        if (en_run > 0) begin
          last_len = en_run;
          en_run = 0;
        end
        low_run++;
      end
      if (a_ack && b_ack) check("dual_ack", 32'd1, 32'd0);
      if (a_ack || b_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_port", {31'd0, b_ack}, {31'd0, e.port});
          check("ack_err", {31'd0, (b_ack ? b_err : a_err)}, {31'd0, e.err});
          check("ack_rdata", {28'd0, (b_ack ? b_rdata : a_rdata)}, {28'd0, e.rdata});
          check("enable_len", last_len, e.en_len);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic port, input logic rnw, input logic [9:0] addr, input logic [3:0] wd);
    if (port) begin
      b_rnw = rnw; b_addr = addr; b_wdata = wd; b_req = 1'b1;
    end else begin
      a_rnw = rnw; a_addr = addr; a_wdata = wd; a_req = 1'b1;
    end
  endtask

  task automatic wait_ack(input logic port);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? b_ack : a_ack) && n < 200);
    if (n >= 200) check("ack_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_enable();
    int n = 0;
    while (!mem_enable && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("enable_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic single(input logic port, input logic rnw, input logic [9:0] addr, input logic [3:0] wd);
    issue(port, rnw, addr, wd);
    wait_ack(port);
    if (port) b_req = 1'b0; else a_req = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    a_req = 1'b0; a_rnw = 1'b0; a_addr = 10'h000; a_wdata = 4'h0;
    b_req = 1'b0; b_rnw = 1'b0; b_addr = 10'h000; b_wdata = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_acks", {28'd0, a_ack, a_err, b_ack, b_err}, 32'd0);
    check("rst_rdata", {24'd0, a_rdata, b_rdata}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    preload = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // A read alone, ready after 2 extra cycles.
    lat = 8'd2;
    expect_ack(1'b0, 1'b0, 4'hC, 3);
    single(1'b0, 1'b1, 10'h3A5, 4'h0);
    check("b_rdata_untouched", {28'd0, b_rdata}, 32'd0);

    // B write then read of the same word.
    lat = 8'd1;
    expect_ack(1'b1, 1'b0, 4'h0, 2);
    single(1'b1, 1'b0, 10'h001, 4'h9);
    lat = 8'd0;
    expect_ack(1'b1, 1'b0, 4'h9, 1);
    single(1'b1, 1'b1, 10'h001, 4'h0);
    check("a_rdata_untouched", {28'd0, a_rdata}, 32'h0000000C);

    // Timeout: no ready at all, then a normal write and read-back.
    no_ready = 1'b1;
    expect_ack(1'b0, 1'b1, 4'hC, 15);
    single(1'b0, 1'b1, 10'h3A5, 4'h0);
    no_ready = 1'b0;
    expect_ack(1'b0, 1'b0, 4'hC, 1);
    single(1'b0, 1'b0, 10'h3A5, 4'h5);
    expect_ack(1'b0, 1'b0, 4'h5, 1);
    single(1'b0, 1'b1, 10'h3A5, 4'h0);

    // Requester changes its address mid-access.
    lat = 8'd4;
    exp_mem_addr = 10'h010;
    addr_chk = 1'b1;
    expect_ack(1'b0, 1'b0, 4'h7, 5);
    issue(1'b0, 1'b1, 10'h010, 4'h0);
    @(negedge clk);
    wait_enable();
    @(negedge clk);
    a_addr = 10'h200;
    wait_ack(1'b0);
    a_req = 1'b0;
    addr_chk = 1'b0;

    // Reset in the middle of an access: no ack, enable drops immediately.
    no_ready = 1'b1;
    issue(1'b0, 1'b1, 10'h200, 4'h0);
    @(negedge clk);
    wait_enable();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_mem_enable", {31'd0, mem_enable}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_ack", {30'd0, a_ack, b_ack}, 32'd0);
    a_req = 1'b0;
    no_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Contention from reset: both held high, grants alternate A,B,A,B.
    lat = 8'd1;
    expect_ack(1'b0, 1'b0, 4'h5, 2);
    expect_ack(1'b1, 1'b0, 4'h9, 2);
    expect_ack(1'b0, 1'b0, 4'h5, 2);
    expect_ack(1'b1, 1'b0, 4'h9, 2);
    a_rnw = 1'b1; a_addr = 10'h3A5; a_wdata = 4'h0;
    b_rnw = 1'b1; b_addr = 10'h001; b_wdata = 4'h0;
    a_req = 1'b1; b_req = 1'b1;
    wait_ack(1'b0);
    wait_ack(1'b1);
    wait_ack(1'b0);
    wait_ack(1'b1);
    a_req = 1'b0; b_req = 1'b0;

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("final_idle", {31'd0, busy}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
